rgb_pwm_generator: RTL and testbench

Generates three PWM waveforms (red, green, blue) from 8-bit duty-cycle values for driving an RGB LED. It is the transmit-side counterpart of the RGB duty-cycle detection path and can be looped back into it for self-test. Duty updates are double-buffered, so a new colour takes effect only at a period boundary, with no glitched or truncated pulses.

---
 rtl/rgb_pwm_pkg.sv | 6 +
 rtl/pwm_channel.sv | 42 ++++
 rtl/rgb_pwm_generator.sv | 86 ++++++++
 tb/tb_rgb_pwm_generator.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/rgb_pwm_pkg.sv
// Shared widths and constants for the RGB PWM transmit path.
package rgb_pwm_pkg;
    localparam int DUTY_W = 8;
    localparam logic [DUTY_W-1:0] PERIOD_LAST = 8'd254;
    typedef logic [DUTY_W-1:0] duty_t;
endpackage

// File: rtl/pwm_channel.sv
// One colour channel: double-buffered duty register, compare and output flop.
module pwm_channel
    import rgb_pwm_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  logic  tick,
    input  logic  wrap,
    input  logic  apply,
    input  logic  capture,
    input  logic  enable,
    input  duty_t count,
    input  duty_t duty_in,
    output logic  pwm_out
);
    duty_t active_q, active_d;
    duty_t pending_q, pending_d;
    logic  pwm_q, pwm_d;

    // apply only means a value is waiting; it lands on the wrap tick or while idle
    always_comb begin
        active_d  = active_q;
        pending_d = pending_q;
        if (apply && ((tick && wrap) || !enable)) active_d = pending_q;
        if (capture) pending_d = duty_in;
        pwm_d = enable && (count < active_q);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            active_q  <= '0;
            pending_q <= '0;
            pwm_q     <= 1'b0;
        end else begin
            active_q  <= active_d;
            pending_q <= pending_d;
            pwm_q     <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;
endmodule

// File: rtl/rgb_pwm_generator.sv
// Three-channel PWM generator: prescaler, 255-tick period counter and load handshake.
module rgb_pwm_generator
    import rgb_pwm_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  enable,
    input  logic  load,
    output logic  load_ready,
    input  duty_t red_duty,
    input  duty_t green_duty,
    input  duty_t blue_duty,
    output logic  rgb_red,
    output logic  rgb_green,
    output logic  rgb_blue,
    output logic  period_start
);
    localparam logic [15:0] PRE_LAST = 16'(CLK_DIV - 1);

    logic [15:0] presc_q, presc_d;
    duty_t       count_q, count_d;
    logic        pending_valid_q, pending_valid_d;
    logic        period_start_q, period_start_d;
    logic        tick, at_last, accept, apply_now;
    duty_t [2:0] duty_in;
    logic  [2:0] pwm;

    assign tick      = enable && (presc_q == PRE_LAST);
    assign at_last   = (count_q == PERIOD_LAST);
    assign accept    = load && !pending_valid_q;
    assign apply_now = pending_valid_q && ((tick && at_last) || !enable);

    always_comb begin
        presc_d = '0;
        count_d = '0;
        if (enable) begin
            presc_d = tick ? 16'd0 : presc_q + 16'd1;
            count_d = count_q;
            if (tick) count_d = at_last ? 8'd0 : count_q + 8'd1;
        end
        // accept and apply_now are exclusive: one needs the flag clear, the other set
        pending_valid_d = pending_valid_q;
        if (apply_now) pending_valid_d = 1'b0;
        if (accept)    pending_valid_d = 1'b1;
        period_start_d = enable && (count_q == '0) && (presc_q == '0);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc_q         <= '0;
            count_q         <= '0;
            pending_valid_q <= 1'b0;
            period_start_q  <= 1'b0;
        end else begin
            presc_q         <= presc_d;
            count_q         <= count_d;
            pending_valid_q <= pending_valid_d;
            period_start_q  <= period_start_d;
        end
    end

    assign duty_in = {blue_duty, green_duty, red_duty};

    for (genvar c = 0; c < 3; c++) begin : g_ch
        pwm_channel u_ch (
            .clock   (clock),
            .reset   (reset),
            .tick    (tick),
            .wrap    (at_last),
            .apply   (pending_valid_q),
            .capture (accept),
            .enable  (enable),
            .count   (count_q),
            .duty_in (duty_in[c]),
            .pwm_out (pwm[c])
        );
    end

    assign rgb_red      = pwm[0];
    assign rgb_green    = pwm[1];
    assign rgb_blue     = pwm[2];
    assign period_start = period_start_q;
    assign load_ready   = !pending_valid_q;
endmodule

// File: tb/tb_rgb_pwm_generator.sv
// Bench for rgb_pwm_generator: CLK_DIV=1 and CLK_DIV=4 instances share one stimulus stream.
module tb_rgb_pwm_generator;
    logic       clock, reset, enable, load;
    logic [7:0] rd, gd, bd;
    logic [1:0] lr, red, grn, blu, ps;

    int total = 0;
    int bad   = 0;

    rgb_pwm_generator #(.CLK_DIV(1)) dut0 (
        .clock(clock), .reset(reset), .enable(enable), .load(load), .load_ready(lr[0]),
        .red_duty(rd), .green_duty(gd), .blue_duty(bd),
        .rgb_red(red[0]), .rgb_green(grn[0]), .rgb_blue(blu[0]), .period_start(ps[0])
    );
    rgb_pwm_generator #(.CLK_DIV(4)) dut1 (
        .clock(clock), .reset(reset), .enable(enable), .load(load), .load_ready(lr[1]),
        .red_duty(rd), .green_duty(gd), .blue_duty(bd),
        .rgb_red(red[1]), .rgb_green(grn[1]), .rgb_blue(blu[1]), .period_start(ps[1])
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: time-based view. t = enabled clocks since the period origin,
    // count = (t / div) % 255; output is the registered compare of that.
    int             m_t   [2];
    logic [2:0][7:0] m_act [2];
    logic [2:0][7:0] m_pend[2];
    logic           m_pv  [2];
    logic [2:0]     e_out [2];
    logic           e_ps  [2];

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                m_t[i] <= 0; m_act[i] <= '0; m_pend[i] <= '0;
                m_pv[i] <= 1'b0; e_out[i] <= '0; e_ps[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                automatic int   dv = (i == 0) ? 1 : 4;
                automatic int   c  = (m_t[i] / dv) % 255;
                automatic int   ph = m_t[i] % dv;
                automatic logic wt = enable && (c == 254) && (ph == dv - 1);
                e_ps[i] <= enable && (m_t[i] % (255 * dv) == 0);
                for (int ch = 0; ch < 3; ch++)
                    e_out[i][ch] <= enable && (c < int'(m_act[i][ch]));
                if (m_pv[i] && (wt || !enable)) begin
                    m_act[i] <= m_pend[i];
                    m_pv[i]  <= 1'b0;
                end
                if (load && !m_pv[i]) begin
                    m_pend[i] <= {bd, gd, rd};
                    m_pv[i]   <= 1'b1;
                end
                m_t[i] <= enable ? m_t[i] + 1 : 0;
            end
        end
    end

    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("red%0d", i),   int'(red[i]), int'(e_out[i][0]));
            chk($sformatf("green%0d", i), int'(grn[i]), int'(e_out[i][1]));
            chk($sformatf("blue%0d", i),  int'(blu[i]), int'(e_out[i][2]));
            chk($sformatf("pstart%0d", i), int'(ps[i]), int'(e_ps[i]));
            chk($sformatf("lready%0d", i), int'(lr[i]), int'(!m_pv[i]));
        end
    end

    // Red high-clock count and length of the most recently completed period.
    int hi[2], len[2], last_hi[2], last_len[2];
    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (ps[i]) begin
                last_hi[i]  <= hi[i];
                last_len[i] <= len[i];
                hi[i]       <= int'(red[i]);
                len[i]      <= 1;
            end else begin
                hi[i]  <= hi[i] + int'(red[i]);
                len[i] <= len[i] + 1;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_load(input int r, input int g, input int b);
        rd = 8'(r); gd = 8'(g); bd = 8'(b);
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
    endtask

    task automatic wait_ps0();
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!ps[0] && n < 300);
        if (!ps[0]) chk("ps0_timeout", 0, 1);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            hi[i] = 0; len[i] = 0; last_hi[i] = 0; last_len[i] = 0;
        end
        reset = 1'b0; enable = 1'b0; load = 1'b0; rd = '0; gd = '0; bd = '0;
        cycles(3);
        chk("rst_red", int'(red), 0);
        chk("rst_lready", int'(lr), 3);
        chk("rst_pstart", int'(ps), 0);
        reset = 1'b1;
        cycles(4);
        chk("idle_pstart", int'(ps), 0);

        // basic duty
        enable = 1'b1;
        do_load(128, 0, 255);
        chk("lready_after_load", int'(lr), 0);
        cycles(1100);
        chk("basic_hi0", last_hi[0], 128);
        chk("basic_len0", last_len[0], 255);
        chk("basic_green0", int'(grn[0]), 0);
        chk("basic_blue0", int'(blu[0]), 1);

        // prescaled duty
        do_load(10, 0, 255);
        cycles(3100);
        chk("presc_hi1", last_hi[1], 40);
        chk("presc_len1", last_len[1], 1020);
        chk("presc_hi0", last_hi[0], 10);

        // double buffer
        do_load(200, 0, 0);
        cycles(2100);
        wait_ps0();
        cycles(50);
        do_load(50, 0, 0);
        chk("dbuf_lready0", int'(lr[0]), 0);
        cycles(2);
        do_load(99, 0, 0);
        wait_ps0();
        chk("dbuf_old_hi0", last_hi[0], 200);
        chk("dbuf_lready_wrap", int'(lr[0]), 1);
        wait_ps0();
        chk("dbuf_new_hi0", last_hi[0], 50);

        // enable low
        cycles(20);
        chk("en_red_high", int'(red[0]), 1);
        enable = 1'b0;
        @(negedge clock);
        chk("en_low_red", int'(red), 0);
        do_load(77, 0, 0);
        chk("en_low_lready_acc", int'(lr[0]), 0);
        @(negedge clock);
        chk("en_low_lready_app", int'(lr[0]), 1);
        enable = 1'b1;
        cycles(1100);
        chk("reen_hi0", last_hi[0], 77);
        chk("reen_hi1", last_hi[1], 308);

        // reset with a load pending
        do_load(33, 44, 55);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("mid_rst_red", int'(red), 0);
        chk("mid_rst_lready", int'(lr), 3);
        cycles(3);
        reset = 1'b1;
        cycles(1100);
        chk("post_rst_hi0", last_hi[0], 0);
        chk("post_rst_hi1", last_hi[1], 0);
        chk("post_rst_blue", int'(blu), 0);
        chk("post_rst_lready", int'(lr), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
